rad4_seq_mult: RTL and testbench
================================

# rad4_seq_mult

Parametrised, iterative radix-4 Booth multiplier: the next generation of the registered exact-multiplier top. It accepts one operand pair per transaction over a valid/ready handshake and retires one Booth digit per clock. It returns the exact double-width product, signed or unsigned per transaction, and holds it until the consumer takes it. It sits between operand producers and downstream datapath stages that tolerate multi-cycle latency in exchange for area.

## Interface
- WIDTH, 16: operand width; even, >= 4.
- DIGITS (localparam), WIDTH/2+1: Booth digits per operation.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier (Booth-recoded).
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with x/y.
- out_valid  out  1  p_out holds a finished product.
- out_ready  in  1  consumer takes product.
- p_out  out  2*WIDTH  exact product.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch the operands:
  - x sign- or zero-extended to WIDTH+2 bits, per signed_mode.
  - y extended the same way to WIDTH+2 bits, with an implicit 0 appended below the LSB.
  - Clear accumulator and digit counter; go to BUSY.
- BUSY: in_ready=0. Each cycle:
  - Recode triplet y_ext[2k+1:2k-1] into a digit in {-2,-1,0,+1,+2}.
  - Add digit*x_ext<<2k to the accumulator, modulo 2^(2*WIDTH).
  - Increment k. After digit k=DIGITS-1, go to DONE.
- Recoding: -2x and -x are formed as inverted partial product plus a +1 carry-in. No separate correction term.
- Accumulator is 2*WIDTH bits and truncation is exact in both modes, because the true product always fits 2*WIDTH bits.
- DONE: out_valid=1 and p_out=accumulator, both stable until out_valid&out_ready. Then go to IDLE with out_valid=0. p_out keeps its last value.
- in_ready is a function of state only. No same-cycle accept while in DONE.
- signed_mode, x and y are ignored outside an accept cycle.

## Timing
- Reset (async assert, any state):
  - state=IDLE, in_ready=1, out_valid=0.
  - p_out=0, accumulator=0, counter=0.
- Reset release is synchronous to clk; the first accept is possible at the first edge after release.
- Mid-operation reset: the in-flight operation is discarded and never presented.
- Latency: if operands are accepted at edge E0, digits are processed at edges E1..E_DIGITS. out_valid rises after E_DIGITS (9 cycles for WIDTH=16).
- Minimum initiation interval: DIGITS+2 cycles (11 for WIDTH=16), reached when out_ready is held high.
- Backpressure: out_ready low holds DONE indefinitely, with no change on p_out.
- Accumulator output is registered; no combinational path from inputs to p_out or out_valid.

## Structure
- Package rad4_pkg:
  - state enum (IDLE/BUSY/DONE).
  - Booth digit struct {zero, two, neg}.
  - function booth_digits(width) returning width/2+1.
  - function encoding a 3-bit triplet into a Booth digit.
- Sub-module rad4_booth_pp (combinational, parameter WIDTH):
  - Inputs: triplet and x_ext.
  - Outputs: a (WIDTH+3)-bit partial product and its carry-in.
  - Reused by future pipelined variants.
- Top level holds the FSM, operand registers, shifter, counter and accumulator.

## Test plan
- Unsigned max, WIDTH=16: x=0xFFFF, y=0xFFFF, signed_mode=0 -> p_out=0xFFFE0001, out_valid 9 cycles after accept.
- Signed corner cases, WIDTH=16, signed_mode=1:
  - 0x8000*0x8000 -> 0x40000000.
  - 0xFFFF*0x0001 -> 0xFFFFFFFF.
  - 0x8000*0x7FFF -> 0xC0008000.
- Mixed values: 0x1234*0x5678 -> 0x06260060 in both modes. Streaming back-to-back with out_ready=1 -> new accept every 11 cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> p_out stable, in_ready=0, and a pending in_valid is not accepted until the cycle after the output handshake.
- Reset mid-BUSY: assert rst at digit 4 -> out_valid=0, p_out=0, in_ready=1 immediately. The next transaction 3*5=15 yields 0x0000000F.
- WIDTH=8 build: randomised 10k operand pairs, both modes, checked against a reference product; out_valid exactly 5 cycles after each accept.

Source files
------------

// File: rtl/rad4_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier family.
package rad4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic two;
    logic neg;
  } booth_digit_t;

  function automatic int booth_digits(input int width);
    return width / 2 + 1;
  endfunction

  // Triplet {y[2k+1], y[2k], y[2k-1]} -> digit in {-2,-1,0,+1,+2}.
  function automatic booth_digit_t booth_encode(input logic [2:0] trip);
    booth_digit_t d;
    case (trip)
      3'b000, 3'b111: d = {1'b1, 1'b0, 1'b0};
      3'b001, 3'b010: d = {1'b0, 1'b0, 1'b0};
      3'b011:         d = {1'b0, 1'b1, 1'b0};
      3'b100:         d = {1'b0, 1'b1, 1'b1};
      3'b101, 3'b110: d = {1'b0, 1'b0, 1'b1};
      default:        d = {1'b1, 1'b0, 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rad4_booth_pp.sv
// One Booth partial product: digit*x_ext, negatives as one's complement plus carry_in.
module rad4_booth_pp
  import rad4_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       triplet,
  input  logic [WIDTH+1:0] x_ext,
  output logic [WIDTH+2:0] pp,
  output logic             carry_in
);

  booth_digit_t     dig_s;
  logic [WIDTH+2:0] mag_s;

  // Select magnitude, then conditionally invert for negative digits.
  always_comb begin
    dig_s = booth_encode(triplet);
    if (dig_s.zero) begin
      mag_s = '0;
    end else if (dig_s.two) begin
      mag_s = {x_ext, 1'b0};
    end else begin
      mag_s = {x_ext[WIDTH+1], x_ext};
    end
    if (dig_s.neg) begin
      pp       = ~mag_s;
      carry_in = 1'b1;
    end else begin
      pp       = mag_s;
      carry_in = 1'b0;
    end
  end

endmodule

// File: rtl/rad4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one digit per clock, valid/ready on both sides.
module rad4_seq_mult
  import rad4_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p_out
);

  localparam int DIGITS = booth_digits(WIDTH);
  localparam int CW     = $clog2(DIGITS);
  localparam int PW     = 2 * WIDTH;

  state_e           state_r;
  logic [WIDTH+1:0] x_ext_r;
  logic [WIDTH+2:0] y_sh_r;
  logic [CW-1:0]    k_r;
  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    p_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [WIDTH+2:0] pp_s;
  logic             cin_s;
  logic [PW-1:0]    pp_ext_s;
  logic [PW-1:0]    term_s;
  logic [PW-1:0]    acc_next_s;
  logic [1:0]       x_fill_s;
  logic [1:0]       y_fill_s;

  rad4_booth_pp #(.WIDTH(WIDTH)) u_pp (
    .triplet  (y_sh_r[2:0]),
    .x_ext    (x_ext_r),
    .pp       (pp_s),
    .carry_in (cin_s)
  );

  // Weight the partial product by 4^k; wrap modulo 2^(2*WIDTH) is exact.
  always_comb begin
    x_fill_s   = signed_mode ? {2{x[WIDTH-1]}} : 2'b00;
    y_fill_s   = signed_mode ? {2{y[WIDTH-1]}} : 2'b00;
    pp_ext_s   = {{(PW-WIDTH-3){pp_s[WIDTH+2]}}, pp_s};
    term_s     = (pp_ext_s + {{(PW-1){1'b0}}, cin_s}) << {k_r, 1'b0};
    acc_next_s = acc_r + term_s;
  end

  // Control FSM with operand, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      x_ext_r     <= '0;
      y_sh_r      <= '0;
      k_r         <= '0;
      acc_r       <= '0;
      p_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_ext_r    <= {x_fill_s, x};
            y_sh_r     <= {y_fill_s, y, 1'b0};
            acc_r      <= '0;
            k_r        <= '0;
            in_ready_r <= 1'b0;
            state_r    <= BUSY;
          end
        end
        BUSY: begin
          acc_r  <= acc_next_s;
          y_sh_r <= {2'b00, y_sh_r[WIDTH+2:2]};
          k_r    <= k_r + 1'b1;
          if (k_r == CW'(DIGITS - 1)) begin
            p_r         <= acc_next_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign p_out     = p_r;

endmodule

// File: tb/tb_rad4_seq_mult.sv
// Directed self-checking bench for rad4_seq_mult at WIDTH=16.
module tb_rad4_seq_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] x = 16'd0;
  logic [15:0] y = 16'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] p_out;

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] VA [10] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000, 16'h1234,
                                      16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0000};
  localparam logic [15:0] VB [10] = '{16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h5678,
                                      16'h5678, 16'h0001, 16'hFFFF, 16'h0003, 16'hABCD};
  localparam logic        VS [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                      1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [31:0] VP [10] = '{32'hFFFE0001, 32'h40000000, 32'hFFFFFFFF, 32'hC0008000, 32'h06260060,
                                      32'h06260060, 32'h0000FFFF, 32'h00000001, 32'hFFFFFFFA, 32'h00000000};

  localparam logic [15:0] SA [3] = '{16'h0003, 16'h7FFF, 16'h00FF};
  localparam logic [15:0] SB [3] = '{16'h0005, 16'h7FFF, 16'h0100};
  localparam logic        SS [3] = '{1'b0, 1'b1, 1'b0};
  localparam logic [31:0] SP [3] = '{32'h0000000F, 32'h3FFF0001, 32'h0000FF00};

  always #5 clk = ~clk;

  rad4_seq_mult #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x           (x),
    .y           (y),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p_out       (p_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sm);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    x = a; y = b; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; x = 16'hDEAD; y = 16'hBEEF; signed_mode = ~sm;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd9);
    chk(tag, p_out, exp);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("take_valid_low", {31'd0, out_valid}, 32'd0);
    chk("take_ready_high", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int idx;
    int pc;
    int lastc;
    bit accepting;
    bit saw_valid;

    // Reset state while rst is held
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_p_out", p_out, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed products, both modes
    for (int i = 0; i < 10; i++) begin
      send(VA[i], VB[i], VS[i]);
      wait_result($sformatf("vec%0d", i), VP[i]);
      take();
    end

    // Streaming with out_ready held high: one accept every 11 cycles
    idx = 0; pc = 0; lastc = -1; accepting = 1'b0;
    x = SA[0]; y = SB[0]; signed_mode = SS[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (in_ready && idx < 3) begin
        if (lastc >= 0) chk("stream_ii", 32'(c - lastc), 32'd11);
        lastc = c;
        accepting = 1'b1;
      end
      if (out_valid && pc < 3) begin
        chk($sformatf("stream_p%0d", pc), p_out, SP[pc]);
        pc++;
      end
      @(posedge clk); #1;
      if (accepting) begin
        idx++;
        accepting = 1'b0;
        if (idx < 3) begin
          x = SA[idx]; y = SB[idx]; signed_mode = SS[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    chk("stream_count", 32'(pc), 32'd3);

    // Backpressure: DONE holds, pending request waits for the handshake
    send(16'h1234, 16'h5678, 1'b0);
    wait_result("bp", 32'h06260060);
    x = 16'h0002; y = 16'h0007; signed_mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_p", p_out, 32'h06260060);
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_after_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_after_hs_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_after_hs_p", p_out, 32'h06260060);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_pending_accepted", {31'd0, in_ready}, 32'd0);
    wait_result("bp_next", 32'h0000000E);
    take();

    // Reset in the middle of BUSY discards the operation
    send(16'hFFFF, 16'hFFFF, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_p", p_out, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_ghost", {31'd0, saw_valid}, 32'd0);
    send(16'h0003, 16'h0005, 1'b0);
    wait_result("post_rst", 32'h0000000F);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
